// File: rtl/pixel_line_buf.sv
// Double-banked scanline buffer between a pixel renderer and a video timing generator.
// One bank is displayed while the other is filled; banks swap at the end of each visible line.
module pixel_line_buf #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600,
  parameter int V_TOTAL   = 628
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hcount_ahead1,
  input  logic [15:0] vcount,
  input  logic        hvis,
  input  logic        vvis,
  input  logic        hsync,
  input  logic        vsync,
  output logic        fill_req,
  output logic [15:0] fill_line,
  input  logic [11:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        underrun
);

  localparam int PW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [11:0]   bank0 [H_VISIBLE];
  logic [11:0]   bank1 [H_VISIBLE];
  logic [11:0]   rd_data;
  logic [1:0]    state;
  logic [PW-1:0] wr_ptr;
  logic          disp_bank;
  logic          swap;
  logic          rd_hit;
  logic          wr_en;
  logic [PW-1:0] rd_addr;
  logic [15:0]   nl;

  assign swap     = (hcount_ahead1 == 16'(H_VISIBLE));
  assign rd_hit   = (hcount_ahead1 < 16'(H_VISIBLE));
  assign rd_addr  = hcount_ahead1[PW-1:0];
  assign nl       = (vcount == 16'(V_TOTAL - 1)) ? 16'd0 : vcount + 16'd1;
  assign wr_ready = (state == S_FILL) && !swap;
  assign wr_en    = wr_valid && wr_ready && !rst;

  // Storage is not reset; the fill bank is always the one not on display.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (disp_bank) bank0[wr_ptr] <= wr_data;
      else           bank1[wr_ptr] <= wr_data;
    end
    if (rd_hit) rd_data <= disp_bank ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {red, green, blue} <= 12'd0;
      hsync_out          <= 1'b0;
      vsync_out          <= 1'b0;
    end else begin
      {red, green, blue} <= (hvis && vvis) ? rd_data : 12'd0;
      hsync_out          <= hsync;
      vsync_out          <= vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      disp_bank <= 1'b0;
      fill_line <= 16'd0;
      fill_req  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      fill_req <= 1'b0;
      if (swap) begin
        disp_bank <= !disp_bank;
        // A fill still in progress is shown partially; flag it and restart.
        if (state == S_FILL) underrun <= 1'b1;
        wr_ptr <= '0;
        if (nl < 16'(V_VISIBLE)) begin
          state     <= S_FILL;
          fill_line <= nl;
          fill_req  <= 1'b1;
        end else begin
          state <= S_IDLE;
        end
      end else if (wr_valid && state == S_FILL) begin
        if (wr_ptr == PW'(H_VISIBLE - 1)) state <= S_DONE;
        else                              wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

endmodule
